// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, length codes and requester indices for the memory port arbiter
package mem_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t BYTE0 = 2'd1;
  localparam state_t BYTE1 = 2'd2;
  localparam state_t DONE  = 2'd3;
  localparam logic LEN_BYTE = 1'b0;
  localparam logic LEN_WORD = 1'b1;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: two-way request picker; round-robin by default, fixed priority when ARB_FIXED_PRIORITY_EN is defined
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifndef ARB_FIXED_PRIORITY_EN
  input  logic ptr,
`endif
  output logic winner,
  output logic valid
);
  always_comb begin
    valid = req0 | req1;
`ifdef ARB_FIXED_PRIORITY_EN
    winner = req0 ? REQ_CPU : REQ_DMA;
`else
    // on a tie the requester that was not served last wins
    winner = (req0 && req1) ? ~ptr : (req1 ? REQ_DMA : REQ_CPU);
`endif
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory port between CPU and DMA, splitting 16-bit accesses into byte cycles
// ARB_FIXED_PRIORITY_EN: requester 0 always wins ties and the round-robin pointer is dropped
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic              Len0,
  input  logic              Len1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [15:0]       WData0,
  input  logic [15:0]       WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic [15:0]       RData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemCS,
  output logic              MemWR,
  output logic [7:0]        MemWData,
  input  logic [7:0]        MemRData,
  output logic              Owner
);
  state_t state, nxt;
  logic wr, len, win, any, access;
  logic [ADDR_W-1:0] addr;
  logic [15:0] wdata;
`ifndef ARB_FIXED_PRIORITY_EN
  logic ptr;
  always_ff @(posedge Clock)
    if (Reset) ptr <= REQ_DMA;
    else if (state == DONE) ptr <= Owner;
`endif
  arb_pick u_pick (
    .req0(Req0),
    .req1(Req1),
`ifndef ARB_FIXED_PRIORITY_EN
    .ptr(ptr),
`endif
    .winner(win),
    .valid(any)
  );
  always_comb
    nxt = state == IDLE  ? (any ? BYTE0 : IDLE) :
          state == BYTE0 ? (len == LEN_WORD ? BYTE1 : DONE) :
          state == BYTE1 ? DONE : IDLE;
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= IDLE;
      wr    <= 1'b0;
      len   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      Owner <= REQ_CPU;
      RData <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        Owner <= win;
        wr    <= win ? Wr1 : Wr0;
        len   <= win ? Len1 : Len0;
        addr  <= win ? Addr1 : Addr0;
        wdata <= win ? WData1 : WData0;
        RData <= '0;
      end
      if (state == BYTE0 && !wr) RData[7:0] <= MemRData;
      if (state == BYTE1 && !wr) RData[15:8] <= MemRData;
    end
  always_comb begin
    access   = state == BYTE0 || state == BYTE1;
    MemCS    = !access;
    MemWR    = access && wr;
    MemAddr  = state == BYTE1 ? addr + ADDR_W'(1) : addr;
    MemWData = state == BYTE1 ? wdata[15:8] : wdata[7:0];
    Gnt0     = state == BYTE0 && Owner == REQ_CPU;
    Gnt1     = state == BYTE0 && Owner == REQ_DMA;
    Done0    = state == DONE && Owner == REQ_CPU;
    Done1    = state == DONE && Owner == REQ_DMA;
  end
endmodule
